// File: rtl/sweep_pkg.sv
// sweep_pkg: shared coordinate types, default spoke origin and FSM state encoding
package sweep_pkg;
    typedef logic [9:0] coord_x_t;
    typedef logic [8:0] coord_y_t;
    localparam coord_x_t DEF_CENTER_X = 10'd200;
    localparam coord_y_t DEF_CENTER_Y = 9'd200;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH_DRAW,
        S_DRAW,
        S_HOLD,
        S_LAUNCH_ERASE,
        S_ERASE,
        S_ADVANCE
    } state_t;
endpackage

// File: rtl/spoke_table.sv
// spoke_table: NUM_SPOKES-entry endpoint register file, one sync write port, one async read port
// Ports: clk, reset (sync, fills every entry with the centre point);
//        i_we/i_waddr/i_wx/i_wy write port (out-of-range addresses dropped);
//        i_raddr -> o_rx/o_ry combinational read.
module spoke_table
    import sweep_pkg::*;
#(
    parameter int       NUM_SPOKES = 12,
    parameter coord_x_t CENTER_X   = DEF_CENTER_X,
    parameter coord_y_t CENTER_Y   = DEF_CENTER_Y,
    localparam int      IW         = $clog2(NUM_SPOKES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [IW-1:0] i_waddr,
    input  coord_x_t      i_wx,
    input  coord_y_t      i_wy,
    input  logic [IW-1:0] i_raddr,
    output coord_x_t      o_rx,
    output coord_y_t      o_ry
);
    coord_x_t r_x [NUM_SPOKES];
    coord_y_t r_y [NUM_SPOKES];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPOKES; i++) begin
                r_x[i] <= CENTER_X;
                r_y[i] <= CENTER_Y;
            end
        end else if (i_we && 32'(i_waddr) < 32'(NUM_SPOKES)) begin
            r_x[i_waddr] <= i_wx;
            r_y[i_waddr] <= i_wy;
        end
    end
    assign o_rx = r_x[i_raddr];
    assign o_ry = r_y[i_raddr];
endmodule

// File: rtl/line_sweep_seq.sv
// line_sweep_seq: radar-style spoke sequencer driving an external line drawer
// Ports: clk, reset (sync active-high); run (level), dir (0 up / 1 down);
//        tbl_we/tbl_addr/tbl_x/tbl_y spoke table write; ld_done from drawer;
//        ld_start, x0/y0/x1/y1, pixel_color to drawer; spoke_idx, busy, wrap status.
// Build option: define SWEEP_ERASE_EN to erase each spoke after its hold time;
//        left undefined, spokes accumulate and HOLD goes straight to ADVANCE.
module line_sweep_seq
    import sweep_pkg::*;
#(
    parameter int       NUM_SPOKES  = 12,
    parameter int       HOLD_CYCLES = 128,
    parameter coord_x_t CENTER_X    = DEF_CENTER_X,
    parameter coord_y_t CENTER_Y    = DEF_CENTER_Y,
    localparam int      IW          = $clog2(NUM_SPOKES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          dir,
    input  logic          tbl_we,
    input  logic [IW-1:0] tbl_addr,
    input  coord_x_t      tbl_x,
    input  coord_y_t      tbl_y,
    input  logic          ld_done,
    output logic          ld_start,
    output coord_x_t      x0,
    output coord_x_t      x1,
    output coord_y_t      y0,
    output coord_y_t      y1,
    output logic          pixel_color,
    output logic [IW-1:0] spoke_idx,
    output logic          busy,
    output logic          wrap
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    state_t        r_state, w_next;
    logic [IW-1:0] r_idx, w_adv_idx, w_rd_idx;
    logic [HW-1:0] r_hold;
    coord_x_t      r_x1, w_tx;
    coord_y_t      r_y1, w_ty;
    logic          w_hold_done, w_at_wrap;

    spoke_table #(.NUM_SPOKES(NUM_SPOKES), .CENTER_X(CENTER_X), .CENTER_Y(CENTER_Y)) u_table (
        .clk(clk), .reset(reset), .i_we(tbl_we), .i_waddr(tbl_addr), .i_wx(tbl_x), .i_wy(tbl_y),
        .i_raddr(w_rd_idx), .o_rx(w_tx), .o_ry(w_ty)
    );

    assign w_at_wrap   = dir ? (r_idx == '0) : (r_idx == IW'(NUM_SPOKES - 1));
    assign w_adv_idx   = w_at_wrap ? (dir ? IW'(NUM_SPOKES - 1) : '0) : (dir ? r_idx - IW'(1) : r_idx + IW'(1));
    // endpoints are latched on the edge into LAUNCH_DRAW, when leaving ADVANCE the new index is not yet registered
    assign w_rd_idx    = (r_state == S_ADVANCE) ? w_adv_idx : r_idx;
    assign w_hold_done = r_hold == HW'(HOLD_CYCLES - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:         w_next = run ? S_LAUNCH_DRAW : S_IDLE;
            S_LAUNCH_DRAW:  w_next = S_DRAW;
            S_DRAW:         w_next = ld_done ? S_HOLD : S_DRAW;
`ifdef SWEEP_ERASE_EN
            S_HOLD:         w_next = w_hold_done ? S_LAUNCH_ERASE : S_HOLD;
            S_LAUNCH_ERASE: w_next = S_ERASE;
            S_ERASE:        w_next = ld_done ? S_ADVANCE : S_ERASE;
`else
            S_HOLD:         w_next = w_hold_done ? S_ADVANCE : S_HOLD;
`endif
            S_ADVANCE:      w_next = run ? S_LAUNCH_DRAW : S_IDLE;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
            r_x1    <= CENTER_X;
            r_y1    <= CENTER_Y;
        end else begin
            r_state <= w_next;
            r_hold  <= (r_state == S_HOLD) ? r_hold + HW'(1) : '0;
            if (r_state == S_ADVANCE) r_idx <= w_adv_idx;
            if (w_next == S_LAUNCH_DRAW) begin
                r_x1 <= w_tx;
                r_y1 <= w_ty;
            end
        end
    end

    assign ld_start  = r_state == S_LAUNCH_DRAW || r_state == S_LAUNCH_ERASE;
    assign busy      = r_state != S_IDLE;
    assign wrap      = r_state == S_ADVANCE && w_at_wrap;
`ifdef SWEEP_ERASE_EN
    assign pixel_color = r_state inside {S_LAUNCH_DRAW, S_DRAW, S_HOLD};
`else
    assign pixel_color = busy;
`endif
    assign x0        = CENTER_X;
    assign y0        = CENTER_Y;
    assign x1        = r_x1;
    assign y1        = r_y1;
    assign spoke_idx = r_idx;
endmodule
